alu4_cmd_seq: RTL and testbench

//  Upstream command sequencer for the 4-bit combinational ALU (ALU4). It accepts one command at a time

---
 rtl/alu4_cmd_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu4_cmd_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_cmd_seq.sv
// ---------------------------------------------------------------------------
// alu4_cmd_seq
//   Command sequencer sitting in front of a 4-bit combinational ALU. It takes
//   one command at a time, presents the operands, function select and carry-in
//   to the ALU for exactly one cycle, and registers the ALU result and flags.
//   It then returns them to a consumer. The accumulator is always the ALU A
//   operand, so a series of commands chains (load, add, add-with-carry, ...).
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
//   valid and ready are both high. The producer holds its payload stable from
//   raising valid until that edge. The consumer may hold ready low for as
//   long as it likes.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready    command channel; cmd_ready is high only in IDLE
//   cmd_op[2:0]        ALU function select
//   cmd_b[W-1:0]       B operand or load value
//   cmd_load           1: load cmd_b into the accumulator, ignore the ALU
//   cmd_usec           add only: carry-in comes from the stored carry flag
//   alu_a/b/c/cin      to the ALU; they are registered and held outside EXEC
//   alu_result, alu_zero, alu_overflow, alu_carry, alu_size   from the ALU
//   res_valid/ready    result channel
//   res_data[W-1:0]    registered result
//   res_flags[3:0]     {carry, overflow, zero, size}
//   acc[W-1:0]         accumulator (observe)
//   dbg_state[1:0]     FSM state (observe)
// ---------------------------------------------------------------------------
module alu4_cmd_seq #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_load,
    input  logic             cmd_usec,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_c,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    input  logic             alu_size,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_flags,
    output logic [WIDTH-1:0] acc,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_load;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_c;
    logic             r_alu_cin;
    logic [WIDTH-1:0] r_res_data;
    logic [3:0]       r_res_flags;

    logic             w_accept;
    logic             w_cin;
    logic [WIDTH-1:0] w_res_data;
    logic [3:0]       w_res_flags;
    logic             w_acc_we;
    logic [WIDTH-1:0] w_acc_d;
    logic             w_carry_we;
    logic             w_carry_d;

    assign cmd_ready = (r_state == S_IDLE);
    assign res_valid = (r_state == S_RESP);
    assign w_accept  = cmd_valid & cmd_ready;

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_c     = r_alu_c;
    assign alu_cin   = r_alu_cin;
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;
    assign acc       = r_acc;
    assign dbg_state = r_state;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (res_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Carry-in is decided when the command is accepted. The stored carry
    // cannot change between acceptance and EXEC, so registering it here
    // gives the same value the ALU would see if it were decided in EXEC.
    // Subtract-style ops (sub, cmp, eq) need cin=1 to finish the two's
    // complement of B inside the ALU.
    always_comb begin
        w_cin = 1'b0;
        case (cmd_op)
            3'b001, 3'b110, 3'b111: w_cin = 1'b1;
            3'b000:                 w_cin = cmd_usec & r_carry;
            default:                w_cin = 1'b0;
        endcase
    end

    // Result, flag and accumulator update applied at the end of EXEC.
    // A load overrides whatever the op field says.
    always_comb begin
        w_res_data  = alu_result;
        w_res_flags = 4'b0000;
        w_acc_we    = 1'b0;
        w_acc_d     = alu_result;
        w_carry_we  = 1'b0;
        w_carry_d   = alu_carry;
        if (r_load) begin
            w_res_data  = r_alu_b;
            w_res_flags = {2'b00, (r_alu_b == '0), 1'b0};
            w_acc_we    = 1'b1;
            w_acc_d     = r_alu_b;
            w_carry_we  = 1'b1;
            w_carry_d   = 1'b0;
        end else begin
            case (r_alu_c)
                3'b000, 3'b001: begin
                    w_res_flags = {alu_carry, alu_overflow, alu_zero, 1'b0};
                    w_acc_we    = 1'b1;
                    w_carry_we  = 1'b1;
                end
                3'b110, 3'b111: begin
                    // Compares report everything but leave acc and carry alone.
                    w_res_flags = {alu_carry, alu_overflow, alu_zero, alu_size};
                end
                default: begin
                    w_res_flags = {2'b00, alu_zero, 1'b0};
                    w_acc_we    = 1'b1;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= ACC_RESET;
            r_carry     <= 1'b0;
            r_load      <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_c     <= 3'b000;
            r_alu_cin   <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= 4'b0000;
        end else begin
            if (w_accept) begin
                r_alu_a   <= r_acc;
                r_alu_b   <= cmd_b;
                r_alu_c   <= cmd_op;
                r_alu_cin <= w_cin;
                r_load    <= cmd_load;
            end
            if (r_state == S_EXEC) begin
                r_res_data  <= w_res_data;
                r_res_flags <= w_res_flags;
                if (w_acc_we) r_acc <= w_acc_d;
                if (w_carry_we) r_carry <= w_carry_d;
            end
        end
    end

endmodule

// File: tb/tb_alu4_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_alu4_cmd_seq
//   Self-checking bench for alu4_cmd_seq. A behavioural 4-bit ALU is wired to
//   the DUT's ALU port. The bench keeps the accumulator, stored carry and
//   response contents as plain variables. It checks every DUT output against
//   them on each falling clock edge, and it checks literal results for the
//   hand-worked command chains.
// ---------------------------------------------------------------------------
module tb_alu4_cmd_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_b;
  logic       cmd_load;
  logic       cmd_usec;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_c;
  logic       alu_cin;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic       alu_size;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [3:0] res_flags;
  logic [3:0] acc;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu4_cmd_seq #(.WIDTH(4), .ACC_RESET(4'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_b        (cmd_b),
    .cmd_load     (cmd_load),
    .cmd_usec     (cmd_usec),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_c        (alu_c),
    .alu_cin      (alu_cin),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .alu_size     (alu_size),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_flags    (res_flags),
    .acc          (acc),
    .dbg_state    (dbg_state)
  );

  // ---------------- behavioural ALU ----------------
  // Returns {carry, overflow, zero, size, result[3:0]}. For logic ops the
  // carry/overflow/size bits are deliberately non-zero noise, so the
  // sequencer's flag masking is visible.
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] c, input logic cin);
    logic [3:0] bb;
    logic [3:0] r;
    logic [4:0] s;
    logic       cy;
    logic       ov;
    logic       sz;
    bb = (c == 3'b000) ? b : ~b;
    s  = {1'b0, a} + {1'b0, bb} + {4'b0000, cin};
    case (c)
      3'b010:  r = ~a;
      3'b011:  r = a & b;
      3'b100:  r = a | b;
      3'b101:  r = a ^ b;
      default: r = s[3:0];
    endcase
    cy = s[4];
    ov = (a[3] == bb[3]) && (s[3] != a[3]);
    case (c)
      3'b110:  sz = (a < b);
      3'b111:  sz = (a == b);
      default: sz = a[0] ^ b[0] ^ 1'b1;
    endcase
    return {cy, ov, (r == 4'h0), sz, r};
  endfunction

  assign {alu_carry, alu_overflow, alu_zero, alu_size, alu_result} =
         alu_ref(alu_a, alu_b, alu_c, alu_cin);

  // ---------------- reference model state ----------------
  logic [3:0] m_acc;
  logic       m_carry;
  logic       exp_cmd_ready;
  logic       exp_res_valid;
  logic [3:0] exp_res_data;
  logic [3:0] exp_res_flags;
  logic [3:0] exp_alu_a;
  logic [3:0] exp_alu_b;
  logic [2:0] exp_alu_c;
  logic       exp_alu_cin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc         = 4'h0;
    m_carry       = 1'b0;
    exp_cmd_ready = 1'b1;
    exp_res_valid = 1'b0;
    exp_res_data  = 4'h0;
    exp_res_flags = 4'h0;
    exp_alu_a     = 4'h0;
    exp_alu_b     = 4'h0;
    exp_alu_c     = 3'b000;
    exp_alu_cin   = 1'b0;
  endtask

  // Carry-in rule, straight from the command semantics.
  function automatic logic model_cin(input logic [2:0] op, input logic usec, input logic carry);
    if (op == 3'b001 || op == 3'b110 || op == 3'b111) return 1'b1;
    if (op == 3'b000 && usec) return carry;
    return 1'b0;
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (!rst) check("cmd_ready", cmd_ready, exp_cmd_ready);
    check("res_valid", res_valid, exp_res_valid);
    check("acc", acc, m_acc);
    check("alu_a", alu_a, exp_alu_a);
    check("alu_b", alu_b, exp_alu_b);
    check("alu_c", alu_c, exp_alu_c);
    check("alu_cin", alu_cin, exp_alu_cin);
    if (exp_res_valid) begin
      check("res_data", res_data, exp_res_data);
      check("res_flags", res_flags, exp_res_flags);
    end
  end

  // ---------------- driver ----------------
  // Entered and left at posedge+1 with the DUT idle.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] b, input logic ld,
                        input logic usec, input int gap, input int stall, input bit junk,
                        output logic [3:0] gd, output logic [3:0] gf, output logic gc);
    logic [7:0] r;
    logic [3:0] d;
    logic [3:0] f;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_b     = b;
    cmd_load  = ld;
    cmd_usec  = usec;
    @(posedge clk); #1;
    // EXEC: the ALU sees the latched command
    exp_cmd_ready = 1'b0;
    exp_alu_a     = m_acc;
    exp_alu_b     = b;
    exp_alu_c     = op;
    exp_alu_cin   = model_cin(op, usec, m_carry);
    gc            = alu_cin;
    if (junk) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_b     = 4'($urandom_range(0, 15));
      cmd_load  = 1'($urandom_range(0, 1));
      cmd_usec  = 1'($urandom_range(0, 1));
      res_ready = 1'($urandom_range(0, 1));
    end else begin
      cmd_valid = 1'b0;
    end
    @(posedge clk); #1;
    // RESP: work out the response from the command rules
    r = alu_ref(m_acc, b, op, exp_alu_cin);
    if (ld) begin
      d = b; f = {2'b00, (b == 4'h0), 1'b0};
      m_acc = b; m_carry = 1'b0;
    end else if (op == 3'b000 || op == 3'b001) begin
      d = r[3:0]; f = {r[7:5], 1'b0};
      m_acc = r[3:0]; m_carry = r[7];
    end else if (op == 3'b110 || op == 3'b111) begin
      d = r[3:0]; f = r[7:4];
    end else begin
      d = r[3:0]; f = {2'b00, r[5], 1'b0};
      m_acc = r[3:0];
    end
    exp_res_valid = 1'b1;
    exp_res_data  = d;
    exp_res_flags = f;
    res_ready     = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    gd = res_data;
    gf = res_flags;
    @(posedge clk); #1;
    res_ready     = 1'b0;
    cmd_valid     = 1'b0;
    exp_res_valid = 1'b0;
    exp_cmd_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  logic [3:0] gd;
  logic [3:0] gf;
  logic       gc;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 3'b000; cmd_b = 4'h0;
    cmd_load = 1'b0; cmd_usec = 1'b0; res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_acc", acc, 4'h0);
    check("reset_res_valid", res_valid, 1'b0);
    check("reset_cmd_ready", cmd_ready, 1'b1);

    // load 3; add 5 -> 8 with signed overflow
    do_cmd(3'b000, 4'h3, 1'b1, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    check("t1_load_data", gd, 4'h3);
    do_cmd(3'b000, 4'h5, 1'b0, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    check("t1_data", gd, 4'h8);
    check("t1_flags", gf, 4'b0100);
    check("t1_acc", acc, 4'h8);

    // load F; add 1 wraps with carry; add-with-carry 0 -> 1
    do_cmd(3'b000, 4'hF, 1'b1, 1'b0, 1, 0, 1'b0, gd, gf, gc);
    do_cmd(3'b000, 4'h1, 1'b0, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    check("t2_data", gd, 4'h0);
    check("t2_flags", gf, 4'b1010);
    do_cmd(3'b000, 4'h0, 1'b0, 1'b1, 0, 0, 1'b0, gd, gf, gc);
    check("t2_usec_cin", gc, 1'b1);
    check("t2_usec_data", gd, 4'h1);
    check("t2_usec_flags", gf, 4'b0000);

    // load 5; eq 5 then eq 4, acc untouched
    do_cmd(3'b000, 4'h5, 1'b1, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    do_cmd(3'b111, 4'h5, 1'b0, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    check("t3_eq_flags", gf, 4'b1011);
    check("t3_eq_acc", acc, 4'h5);
    do_cmd(3'b111, 4'h4, 1'b0, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    check("t3_ne_flags", gf, 4'b1000);
    check("t3_ne_acc", acc, 4'h5);

    // consumer stalls 5 cycles; the compare process watches stability
    do_cmd(3'b001, 4'h2, 1'b0, 1'b0, 0, 5, 1'b0, gd, gf, gc);
    check("t4_sub_data", gd, 4'h3);
    check("t4_idle_after", cmd_ready, 1'b1);

    // load A; and C -> 8, cin 0
    do_cmd(3'b000, 4'hA, 1'b1, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    do_cmd(3'b011, 4'hC, 1'b0, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    check("t6_data", gd, 4'h8);
    check("t6_flags", gf, 4'b0000);
    check("t6_cin", gc, 1'b0);

    // stored carry survives a logic op: F+1 sets carry, or, then adc 0
    do_cmd(3'b000, 4'hF, 1'b1, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    do_cmd(3'b000, 4'h1, 1'b0, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    do_cmd(3'b100, 4'h6, 1'b0, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    check("t7_or_data", gd, 4'h6);
    do_cmd(3'b000, 4'h0, 1'b0, 1'b1, 0, 0, 1'b0, gd, gf, gc);
    check("t7_carry_kept", gd, 4'h7);

    // asynchronous reset in the middle of EXEC
    do_cmd(3'b000, 4'h9, 1'b1, 1'b0, 0, 0, 1'b0, gd, gf, gc);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_b = 4'h3; cmd_load = 1'b0; cmd_usec = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    cmd_valid = 1'b0;
    #1;
    check("t5_acc", acc, 4'h0);
    check("t5_alu_a", alu_a, 4'h0);
    check("t5_alu_b", alu_b, 4'h0);
    check("t5_alu_c", alu_c, 3'b000);
    check("t5_alu_cin", alu_cin, 1'b0);
    check("t5_res_valid", res_valid, 1'b0);
    check("t5_res_data", res_data, 4'h0);
    check("t5_res_flags", res_flags, 4'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_resp", res_valid, 1'b0);
    // stored carry was cleared too: adc 0 on acc 0 gives 0
    do_cmd(3'b000, 4'h0, 1'b0, 1'b1, 0, 0, 1'b0, gd, gf, gc);
    check("t5_carry_cleared", gd, 4'h0);

    // randomized chains
    for (int i = 0; i < 250; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1, gd, gf, gc);
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
